// File: rtl/bus_port.sv
// bus_port: per-processor endpoint of the shared 16-bit snooping bus.
//   Outbound: a DEPTH-entry FIFO queues messages from the cache controller.
//   The head word is presented on bus_out_o with bus_req_o raised until a
//   grant (proc_i == PROC_ID) pops it. One idle cycle follows every send.
//   Inbound: the arbiter's registered bus is watched. Foreign, non-idle
//   changes are reported as one-cycle snoop pulses.
// Bus word: [15:14] op (00 idle, 01 rd-miss, 10 wr-miss, 11 inval),
//           [13:12] source id, [11:0] address.
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   proc_i         current grant (same select the arbiter uses)
//   tx_valid_i     tx_word_i offered by the cache controller
//   tx_word_i      outbound message; source field replaced by PROC_ID
//   tx_ready_o     FIFO not full; push on tx_valid_i && tx_ready_o
//   bus_req_o      port holds a word and wants the bus
//   bus_out_o      word to the arbiter; zero when not sending
//   bus_in_i       arbiter's registered bus output
//   snoop_valid_o  one-cycle pulse: new foreign message on snoop_word_o
//   snoop_word_o   last captured foreign message
//   timeout_err_o  sticky grant-timeout flag
// Optional feature: define BUS_PORT_TIMEOUT_EN to enable the grant-timeout
// counter. Without it, timeout_err_o is constant 0.
module bus_port #(
   parameter logic [1:0]  PROC_ID        = 2'd0,
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  proc_i,
   input  logic        tx_valid_i,
   input  logic [15:0] tx_word_i,
   output logic        tx_ready_o,
   output logic        bus_req_o,
   output logic [15:0] bus_out_o,
   input  logic [15:0] bus_in_i,
   output logic        snoop_valid_o,
   output logic [15:0] snoop_word_o,
   output logic        timeout_err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   // Elaboration guards on the configuration
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("bus_port: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("bus_port: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RELEASE = 2'd2
   } state_e;

   state_e         state_q;
   logic [15:0]    mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [15:0]    bus_out_q;
   logic           bus_req_q;
   logic [15:0]    last_bus_q;
   logic           snoop_valid_q;
   logic [15:0]    snoop_word_q;

   logic           full_c, empty_c, push_c, pop_c, snoop_hit_c;
   logic           unused_src;

   // Source field of the offered word is always overwritten
   assign unused_src = ^tx_word_i[13:12];

   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign push_c  = tx_valid_i && !full_c;
   // Arbiter samples bus_out at this edge, so the head leaves the FIFO now
   assign pop_c   = (state_q == S_WAIT) && (proc_i == PROC_ID);

   assign tx_ready_o    = !full_c;
   assign bus_req_o     = bus_req_q;
   assign bus_out_o     = bus_out_q;
   assign snoop_valid_o = snoop_valid_q;
   assign snoop_word_o  = snoop_word_q;

   // FIFO storage (no reset needed: guarded by count)
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= {tx_word_i[15:14], PROC_ID, tx_word_i[11:0]};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   // Send FSM. RELEASE drives zero for one cycle and then reloads directly
   // when more words are queued, so consecutive sends are spaced by exactly
   // one idle bus word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         bus_out_q <= '0;
         bus_req_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_RELEASE: begin
               if (!empty_c) begin
                  bus_out_q <= mem_q[rd_ptr_q];
                  bus_req_q <= 1'b1;
                  state_q   <= S_WAIT;
               end else begin
                  bus_out_q <= '0;
                  bus_req_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (pop_c) begin
                  bus_out_q <= '0;
                  bus_req_q <= 1'b0;
                  state_q   <= S_RELEASE;
               end
            end
            default: begin
               bus_out_q <= '0;
               bus_req_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   // Foreign, non-idle, changed bus words are reported once
   assign snoop_hit_c = (bus_in_i != last_bus_q) &&
                        (bus_in_i[15:14] != 2'b00) &&
                        (bus_in_i[13:12] != PROC_ID);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_bus_q    <= '0;
         snoop_valid_q <= 1'b0;
         snoop_word_q  <= '0;
      end else begin
         last_bus_q    <= bus_in_i;
         snoop_valid_q <= snoop_hit_c;
         if (snoop_hit_c) snoop_word_q <= bus_in_i;
      end
   end

`ifdef BUS_PORT_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt_q;
   logic          timeout_err_q;

   // Counter is held at zero outside WAIT, so it starts from zero on entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else if (state_q != S_WAIT) begin
         to_cnt_q <= '0;
      end else if (!pop_c && (to_cnt_q != TW'(TIMEOUT_CYCLES))) begin
         to_cnt_q <= to_cnt_q + TW'(1);
         if ((to_cnt_q + TW'(1)) == TW'(TIMEOUT_CYCLES)) timeout_err_q <= 1'b1;
      end
   end

   assign timeout_err_o = timeout_err_q;
`else
   assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_port.sv
// Self-checking bench for bus_port (PROC_ID=1, DEPTH=4): snoop vector table,
// directed multi-cycle sequences, and randomized traffic against a
// queue-based reference model.
module tb_bus_port;
   localparam logic [1:0] ID    = 2'd1;
   localparam int         DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  proc = 2'd0;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_word = '0;
   logic        tx_ready;
   logic        bus_req;
   logic [15:0] bus_out;
   logic [15:0] bus_in = '0;
   logic        snoop_valid;
   logic [15:0] snoop_word;
   logic        timeout_err;

   int checks = 0;
   int failures = 0;

   bus_port #(.PROC_ID(ID), .DEPTH(DEPTH), .TIMEOUT_CYCLES(15)) dut (
      .clk_i(clk), .rst_ni(rst_n), .proc_i(proc),
      .tx_valid_i(tx_valid), .tx_word_i(tx_word), .tx_ready_o(tx_ready),
      .bus_req_o(bus_req), .bus_out_o(bus_out), .bus_in_i(bus_in),
      .snoop_valid_o(snoop_valid), .snoop_word_o(snoop_word),
      .timeout_err_o(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bus_in;
      logic        exp_valid;
      logic [15:0] exp_word;
   } snoop_vec_t;

   snoop_vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] tag(input logic [15:0] w);
      return {w[15:14], ID, w[11:0]};
   endfunction

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w2 [5];
      logic [15:0] w4 [4];
      logic [15:0] q[$];
      logic [15:0] pool [8];
      logic [15:0] prev_bus, exp_sw;
      logic        exp_sv, last_grant, grant, push_ok;
      int          stall;

      tbl[0]  = '{16'h8A05, 1'b1, 16'h8A05};
      tbl[1]  = '{16'h8A05, 1'b0, 16'h8A05};
      tbl[2]  = '{16'h8A05, 1'b0, 16'h8A05};
      tbl[3]  = '{16'h5123, 1'b0, 16'h8A05};
      tbl[4]  = '{16'h5123, 1'b0, 16'h8A05};
      tbl[5]  = '{16'h0000, 1'b0, 16'h8A05};
      tbl[6]  = '{16'hC0FF, 1'b1, 16'hC0FF};
      tbl[7]  = '{16'h3FFF, 1'b0, 16'hC0FF};
      tbl[8]  = '{16'h6ABC, 1'b1, 16'h6ABC};
      tbl[9]  = '{16'hD000, 1'b0, 16'h6ABC};
      tbl[10] = '{16'h8A05, 1'b1, 16'h8A05};
      tbl[11] = '{16'h0000, 1'b0, 16'h8A05};

      // Reset state
      @(negedge clk);
      tick();
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_out", bus_out, 0);
      chk("rst_snoop_valid", snoop_valid, 0);
      chk("rst_snoop_word", snoop_word, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_tx_ready", tx_ready, 1);
      rst_n = 1'b1;
      tick();

      // Snoop vector table
      for (int i = 0; i < 12; i++) begin
         bus_in = tbl[i].bus_in;
         tick();
         chk($sformatf("snoop_valid[%0d]", i), snoop_valid, tbl[i].exp_valid);
         chk($sformatf("snoop_word[%0d]", i), snoop_word, tbl[i].exp_word);
      end
      bus_in = '0;

      // Single send with delayed grant
      proc = 2'd0;
      tx_valid = 1'b1; tx_word = 16'h4123;
      tick();
      tx_valid = 1'b0;
      chk("t1_req_cycle1", bus_req, 0);
      tick();
      chk("t1_req", bus_req, 1);
      chk("t1_out", bus_out, 16'h5123);
      tick();
      tick();
      chk("t1_out_held", bus_out, 16'h5123);
      proc = ID;
      tick();
      proc = 2'd0;
      chk("t1_out_after_grant", bus_out, 0);
      chk("t1_req_after_grant", bus_req, 0);
      tick();
      chk("t1_idle_out", bus_out, 0);
      chk("t1_tx_ready", tx_ready, 1);

      // Fill to full with no grants, 5th push dropped, then drain in order
      w2[0] = 16'h4AAA; w2[1] = 16'h8BBB; w2[2] = 16'hCCCC;
      w2[3] = 16'h4DDD; w2[4] = 16'h8EEE;
      proc = 2'd3;
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1'b1; tx_word = w2[i];
         chk($sformatf("t2_tx_ready[%0d]", i), tx_ready, (i < 4) ? 1 : 0);
         tick();
      end
      tx_valid = 1'b0;
      chk("t2_full", tx_ready, 0);
      proc = ID;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_word[%0d]", i), bus_out, tag(w2[i]));
         chk($sformatf("t2_req[%0d]", i), bus_req, 1);
         tick();
         chk($sformatf("t2_gap[%0d]", i), {bus_req, bus_out}, 0);
         tick();
      end
      chk("t2_empty_req", bus_req, 0);
      chk("t2_empty_ready", tx_ready, 1);
      proc = 2'd0;
      tick();

      // Push coinciding with grant pop at count DEPTH-1
      w4[0] = 16'h4001; w4[1] = 16'h8002; w4[2] = 16'hC003; w4[3] = 16'h4004;
      proc = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tx_valid = 1'b1; tx_word = w4[i];
         tick();
      end
      chk("t4_head", bus_out, tag(w4[0]));
      chk("t4_ready_before", tx_ready, 1);
      proc = ID; tx_valid = 1'b1; tx_word = w4[3];
      tick();
      tx_valid = 1'b0;
      chk("t4_ready_after", tx_ready, 1);
      chk("t4_gap", bus_out, 0);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk($sformatf("t4_word[%0d]", i), bus_out, tag(w4[i]));
         tick();
         chk($sformatf("t4_gap[%0d]", i), bus_out, 0);
      end
      tick();
      chk("t4_drained", bus_req, 0);
      proc = 2'd0;

      // Asynchronous reset while waiting with two words queued
      proc = 2'd3;
      tx_valid = 1'b1; tx_word = 16'h8111; tick();
      tx_word = 16'h4222; tick();
      tx_valid = 1'b0;
      chk("t5_waiting", bus_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_req", bus_req, 0);
      chk("t5_async_out", bus_out, 0);
      chk("t5_async_ready", tx_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("t5_idle_req", bus_req, 0);
      chk("t5_idle_ready", tx_ready, 1);
      proc = ID;
      tick();
      chk("t5_nothing_sent", bus_out, 0);
      proc = 2'd0;

      // Randomized traffic against a queue-level model
      pulse_reset();
      pool[0] = 16'h0000; pool[1] = 16'h8A05; pool[2] = 16'h5123; pool[3] = 16'h6ABC;
      pool[4] = 16'hC2F0; pool[5] = 16'h3FFF; pool[6] = 16'hD000; pool[7] = 16'h4111;
      q.delete();
      prev_bus = '0; exp_sv = 1'b0; exp_sw = '0; last_grant = 1'b0; stall = 0;
      for (int c = 0; c < 1500; c++) begin
         chk("rnd_tx_ready", tx_ready, (q.size() < DEPTH) ? 1 : 0);
         chk("rnd_snoop_valid", snoop_valid, exp_sv);
         chk("rnd_snoop_word", snoop_word, exp_sw);
         if (last_grant) chk("rnd_gap", {bus_req, bus_out}, 0);
         if (bus_req) begin
            if (q.size() == 0) chk("rnd_spurious_req", bus_req, 0);
            else chk("rnd_bus_out", bus_out, q[0]);
         end else begin
            chk("rnd_idle_out", bus_out, 0);
         end
         if ((q.size() != 0) && !bus_req) stall++;
         else stall = 0;
         chk("rnd_stall", (stall <= 1) ? 1 : 0, 1);

         tx_valid = ($urandom_range(0, 2) != 0);
         tx_word  = 16'($urandom);
         proc     = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) bus_in = pool[$urandom_range(0, 7)];
         push_ok = tx_valid && (q.size() < DEPTH);
         grant   = bus_req && (proc == ID);
         tick();
         if (grant && (q.size() != 0)) void'(q.pop_front());
         if (push_ok) q.push_back(tag(tx_word));
         exp_sv = (bus_in != prev_bus) && (bus_in[15:14] != 2'b00) && (bus_in[13:12] != ID);
         if (exp_sv) exp_sw = bus_in;
         prev_bus = bus_in;
         last_grant = grant;
      end
      tx_valid = 1'b0;
      bus_in = '0;

      // Grant timeout
      pulse_reset();
      proc = 2'd0;
      tx_valid = 1'b1; tx_word = 16'h4123;
      tick();
      tx_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("t6_early", timeout_err, 0);
      for (int i = 0; i < 15; i++) tick();
`ifdef BUS_PORT_TIMEOUT_EN
      chk("t6_set", timeout_err, 1);
`else
      chk("t6_off", timeout_err, 0);
`endif
      chk("t6_still_wait", bus_out, 16'h5123);
      proc = ID;
      tick();
      proc = 2'd0;
      tick();
      tick();
      chk("t6_sent", bus_req, 0);
`ifdef BUS_PORT_TIMEOUT_EN
      chk("t6_sticky", timeout_err, 1);
`else
      chk("t6_off_after", timeout_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
